// File: rtl/seg_p2s.sv
// Parallel-to-serial frame shifter for a serial-driven seven-segment/LED chain.
// Shifts a captured frame out MSB-first on a divided clock, then strobes the chain latch.
module seg_p2s #(
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] p_data,
  output logic                 busy,
  output logic                 done,
  output logic                 s_clk,
  output logic                 s_data,
  output logic                 s_latch,
  output logic                 s_pen,
  output logic                 s_clrn
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [CNT_W-1:0]     r_bits;
  logic [DIV_W-1:0]     r_div;

  logic                 w_div_end;
  logic [DATA_BITS-1:0] w_shift_nxt;

  assign w_div_end   = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_shift_nxt = r_shift << 1;

  // Frame sequencer; every output is driven straight from this register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bits  <= '0;
      r_div   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_clk   <= 1'b0;
      s_data  <= 1'b0;
      s_latch <= 1'b0;
      s_pen   <= 1'b0;
      s_clrn  <= 1'b0;
    end else begin
      s_clrn <= 1'b1;
      done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= p_data;
            r_bits  <= CNT_W'(DATA_BITS);
            r_div   <= '0;
            r_state <= SHIFT_LO;
            busy    <= 1'b1;
            s_clk   <= 1'b0;
            s_data  <= p_data[DATA_BITS-1];
          end
        end
        SHIFT_LO: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= SHIFT_HI;
            s_clk   <= 1'b1;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        SHIFT_HI: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_shift <= w_shift_nxt;
            r_bits  <= r_bits - CNT_W'(1);
            s_clk   <= 1'b0;
            // Next bit is presented on the same edge s_clk falls, so it is settled before the next rise.
            if (r_bits == CNT_W'(1)) begin
              r_state <= LATCH;
              s_latch <= 1'b1;
            end else begin
              r_state <= SHIFT_LO;
              s_data  <= w_shift_nxt[DATA_BITS-1];
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        LATCH: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= IDLE;
            s_latch <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            s_pen   <= 1'b1;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seg_p2s.md
# seg_p2s

Parallel-to-serial shifter for the board's serial-driven seven-segment and LED chain. It sits directly downstream of the segment-pattern mapping stage. It captures a full frame of segment bytes in parallel and shifts it out MSB-first on a divided serial clock. It then pulses a latch so the external shift-register chain updates all digits at once. A start/busy/done handshake lets the display controller pace frame refreshes.

## Interface
- `DATA_BITS`, default 64: frame width in bits (8 digits × 8 segment bits); must be ≥1.
- `CLK_DIV`, default 2: serial clock half-period in `clk` cycles; must be ≥1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  frame request; sampled only when `busy`=0.
- `p_data`  in  DATA_BITS  frame pattern; captured on the accepted `start` edge.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame completion.
- `s_clk`  out  1  serial shift clock; the external chain samples on its rising edge.
- `s_data`  out  1  serial data.
- `s_latch`  out  1  storage latch strobe; active high.
- `s_pen`  out  1  display output enable; active high.
- `s_clrn`  out  1  external chain clear; active low.

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- A start is accepted on a rising edge with `start`=1 in IDLE. On acceptance:
  - the shift register loads `p_data`;
  - the bit counter loads DATA_BITS;
  - the divider counter clears;
  - the state goes to SHIFT_LO.
- `start` is ignored in all other states. `p_data` changes after capture have no effect on the current frame.
- SHIFT_LO: `s_clk`=0 and `s_data`=shift-register MSB. After CLK_DIV cycles the state goes to SHIFT_HI.
- SHIFT_HI: `s_clk`=1 for CLK_DIV cycles. On exit, the shift register shifts left by one and the bit counter decrements.
  - Counter still nonzero: go to SHIFT_LO.
  - Counter reaches 0: go to LATCH.
- LATCH: `s_clk`=0 and `s_latch`=1 for CLK_DIV cycles, then go to IDLE. In that transition cycle `done`=1, and `s_pen` is set to 1.
- Bit order: `p_data[DATA_BITS-1]` goes out first and `p_data[0]` goes out last.
- Counter widths: the divider counter is $clog2(CLK_DIV) bits, minimum 1; the bit counter is $clog2(DATA_BITS+1) bits. Neither counter wraps.
- `s_data` changes only while `s_clk`=0, so it is stable across every rising edge of `s_clk`.
- In IDLE and LATCH, `s_data` holds the last shifted-out value.
- `s_pen` stays 1 from the first completed frame until reset. It is never cleared mid-operation, so the previous digits remain lit while a new frame shifts.
- `s_clrn` is 0 while `rst_n`=0 and is registered to 1 on the first clock after reset release.
- Reset mid-frame aborts the frame immediately: every output returns to its reset value, the state returns to IDLE, and no `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `s_clk`=0, `s_data`=0, `s_latch`=0, `s_pen`=0, `s_clrn`=0.
- Start accepted at edge 0 ⇒ `busy`=1 from cycle 1. The first bit is valid on `s_data` in cycle 1.
- Bit k (0-based) timing:
  - `s_clk` low over cycles 1+2·CLK_DIV·k … CLK_DIV·(2k+1);
  - `s_clk` high for the following CLK_DIV cycles.
- `s_latch` is high for the CLK_DIV cycles after the last high phase.
- `busy` lasts exactly 2·CLK_DIV·DATA_BITS + CLK_DIV cycles: 258 cycles at the defaults.
- `done`=1 and `busy`=0 in the next cycle: cycle 259 at the defaults.
- A `start` in the `done` cycle is accepted, giving back-to-back frames with no idle gap.
- `busy`, `done` and all serial outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
- Reset check: hold `rst_n`=0 for 5 cycles, then release → all outputs at reset values; `s_clrn`=1 one cycle after release; `busy` stays 0 with no `start`.
- Single frame: `start` pulse with `p_data`=64'h8000_0000_0000_0001, defaults → sampling `s_data` on each `s_clk` rising edge yields 1, 62 zeros, 1.
  - Exactly 64 `s_clk` rising edges.
  - `s_latch` high in cycles 257–258; `done` in cycle 259; `s_pen`=1 from cycle 259.
- Start while busy: second `start` at cycle 50 with a different `p_data` → ignored; the serial stream matches the first frame; one `done` only.
- Back-to-back: hold `start`=1 continuously with `p_data`=64'hFFFF_0000_AAAA_5555 → frames repeat every 259 cycles; `busy` is low only in the `done` cycles; every frame's stream equals the pattern.
- Reset mid-frame: assert `rst_n`=0 at cycle 100 → all outputs at reset values asynchronously, no `done`, and `s_pen` returns to 0.
  - Then start a new frame with 64'h0123_4567_89AB_CDEF → correct stream.
- Parameter corner: DATA_BITS=8, CLK_DIV=1, `p_data`=8'hA5 → stream 1,0,1,0,0,1,0,1; `busy` for 17 cycles; `done` in cycle 18.
